// File: rtl/seg_scan_decoder.sv
// Readback decoder for the multiplexed MM:SS 7-segment drive: resamples the scan,
// decodes each digit back to BCD and publishes minutes/seconds once frames repeat.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int TO_W           = 22
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic [3:0] anode,
  input  logic [6:0] cathode,
  input  logic       clear_err,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       value_valid,
  output logic       frame_strobe,
  output logic       err_pattern,
  output logic       err_anode,
  output logic       err_range
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int MC_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [MC_W-1:0] MATCH_FULL  = MC_W'(STABLE_FRAMES);
  localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(TIMEOUT_CYCLES);

  // Returns {invalid, digit}; anything outside the ten digit shapes is invalid.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
      default:    return 5'h10;
    endcase
  endfunction

  function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({2'b00, tens} * 6'd10) + {2'b00, ones};
  endfunction

  function automatic logic [MC_W-1:0] match_inc(input logic [MC_W-1:0] cnt);
    return (cnt >= MATCH_FULL) ? MATCH_FULL : cnt + 1'b1;
  endfunction

  logic [3:0]      anode_p0, anode_p1, anode_p2;
  logic [6:0]      cathode_p0, cathode_p1, cathode_p2;
  logic [1:0]      fill;
  logic [SC_W-1:0] settle_cnt, settle_nxt;
  logic            captured;
  logic [3:0][3:0] slot_digit;
  logic [3:0]      slot_inv;
  logic [3:0]      mask, mask_base, sel;
  logic            frame_pend;
  logic [15:0]     candidate;
  logic [MC_W-1:0] match_cnt, match_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            same, anode_blank, anode_onehot, anode_bad, capture;
  logic            frame_inv, frame_range, accept;
  logic [4:0]      dec;

  // Sample classification, settle timing and frame evaluation
  always_comb begin
    sel          = ~anode_p1;
    same         = ({anode_p1, cathode_p1} == {anode_p2, cathode_p2});
    anode_blank  = (anode_p1 == 4'hF);
    anode_onehot = (sel == 4'b0001) || (sel == 4'b0010) || (sel == 4'b0100) || (sel == 4'b1000);
    // fill gates out the synchronizer reset value, which is not a real anode sample
    anode_bad    = fill[1] && !anode_blank && !anode_onehot;
    if (!same || anode_bad)
      settle_nxt = '0;
    else if (settle_cnt == SETTLE_LAST)
      settle_nxt = settle_cnt;
    else
      settle_nxt = settle_cnt + 1'b1;
    capture     = fill[1] && same && anode_onehot && !captured && (settle_nxt == SETTLE_LAST);
    dec         = seg_decode(cathode_p1);
    mask_base   = frame_pend ? 4'h0 : mask;
    frame_inv   = |slot_inv;
    frame_range = (slot_digit[3] > 4'd5) || (slot_digit[1] > 4'd5);
    accept      = frame_pend && !frame_inv && !frame_range;
    match_nxt   = (slot_digit == candidate) ? match_inc(match_cnt) : MC_W'(1);
  end

  // Synchronizers, capture control, frame matching and outputs
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      anode_p0     <= '0;
      anode_p1     <= '0;
      anode_p2     <= '0;
      cathode_p0   <= '0;
      cathode_p1   <= '0;
      cathode_p2   <= '0;
      fill         <= '0;
      settle_cnt   <= '0;
      captured     <= 1'b0;
      mask         <= '0;
      frame_pend   <= 1'b0;
      candidate    <= '0;
      match_cnt    <= '0;
      to_cnt       <= '0;
      minutes      <= '0;
      seconds      <= '0;
      value_valid  <= 1'b0;
      frame_strobe <= 1'b0;
      err_pattern  <= 1'b0;
      err_anode    <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      anode_p0   <= anode;
      anode_p1   <= anode_p0;
      anode_p2   <= anode_p1;
      cathode_p0 <= cathode;
      cathode_p1 <= cathode_p0;
      cathode_p2 <= cathode_p1;
      fill       <= {fill[0], 1'b1};
      settle_cnt <= settle_nxt;
      captured   <= (!same || anode_bad) ? 1'b0 : (captured | capture);

      mask       <= capture ? (mask_base | sel) : mask_base;
      frame_pend <= capture && ((mask_base | sel) == 4'hF);

      frame_strobe <= accept;
      err_anode    <= anode_bad | (err_anode & ~clear_err);
      err_pattern  <= (frame_pend & frame_inv) | (err_pattern & ~clear_err);
      err_range    <= (frame_pend & ~frame_inv & frame_range) | (err_range & ~clear_err);

      if (accept) begin
        to_cnt    <= '0;
        candidate <= slot_digit;
        match_cnt <= match_nxt;
        if (match_nxt == MATCH_FULL) begin
          minutes     <= bcd_to_bin(slot_digit[3], slot_digit[2]);
          seconds     <= bcd_to_bin(slot_digit[1], slot_digit[0]);
          value_valid <= 1'b1;
        end
      end else begin
        if (to_cnt != TO_LIMIT)
          to_cnt <= to_cnt + 1'b1;
        if (frame_pend || (to_cnt == TO_LIMIT))
          match_cnt <= '0;
        if (to_cnt == TO_LIMIT)
          value_valid <= 1'b0;
      end
    end
  end

  // Slot contents are only meaningful under the mask, so they carry no reset
  always_ff @(posedge clock_in) begin
    for (int i = 0; i < 4; i++) begin
      if (capture && sel[i]) begin
        slot_digit[i] <= dec[3:0];
        slot_inv[i]   <= dec[4];
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch's multiplexed 4-digit 7-segment drive.
- Samples the scanned anode and cathode lines and decodes each cathode pattern back to BCD.
- Reassembles complete MM:SS frames and publishes minutes/seconds once consecutive frames agree.
- Used as on-board readback and self-check of the display path, with sticky error flags for malformed scans.

Parameters:
SETTLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured
STABLE_FRAMES, 2, consecutive identical valid frames required before outputs update
TIMEOUT_CYCLES, 4000000, clock_in cycles without an accepted frame before value_valid drops
TO_W, 22, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clock_in  in  1  master clock
reset  in  1  asynchronous, active-high reset
anode  in  4  active-low digit enables; 0111=min tens, 1011=min ones, 1101=sec tens, 1110=sec ones
cathode  in  7  active-low segments, bit6=a .. bit0=g
clear_err  in  1  synchronous clear of the sticky error flags
minutes  out  6  decoded minutes, 0..59
seconds  out  6  decoded seconds, 0..59
value_valid  out  1  minutes/seconds are current and confirmed
frame_strobe  out  1  one-cycle pulse per accepted frame
err_pattern  out  1  sticky: non-digit cathode pattern captured
err_anode  out  1  sticky: anode neither one-hot-low nor 1111
err_range  out  1  sticky: tens digit of minutes or seconds > 5

Behaviour:
- Reset (asynchronous): all outputs, synchronizers, counters, slot mask and candidate frame go to 0.
- Input sync: anode and cathode pass through 2-flop synchronizers. All timing below is in synchronized samples.
- Settle counter:
  - Increments while {anode, cathode} equals the previous sample; any change zeroes it.
  - Capture fires exactly once when the counter reaches SETTLE_CYCLES-1. A captured flag blocks recapture until the next change.
- Anode handling:
  - 1111 = blank: no capture, no error.
  - Any other non-one-hot-low value: set err_anode, zero the settle counter, no capture.
- Decode table (cathode -> digit): 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9. Any other pattern is invalid.
- Capture: writes the digit and its invalid bit into the anode's slot and sets that slot's mask bit. Recapturing a slot before the frame completes overwrites it.
- Frame completion:
  - The frame completes on the capture that makes the mask 1111.
  - On the following cycle the mask clears and the frame is evaluated.
- Frame evaluation (same cycle as the mask clear), checked in this order:
  - Any invalid slot -> set err_pattern; discard the frame; match count = 0.
  - Else min tens > 5 or sec tens > 5 -> set err_range; discard; match count = 0.
  - Else the frame is accepted: frame_strobe = 1 for one cycle and the timeout counter zeroes.
    - If the frame equals the candidate, match count increments, saturating at STABLE_FRAMES.
    - Otherwise candidate = frame and match count = 1.
- Output update:
  - When match count equals STABLE_FRAMES after an accepted frame, minutes = tens*10 + ones and seconds = tens*10 + ones (6-bit), and value_valid = 1.
  - Registered in the frame_strobe cycle; latency from the completing capture is 1 cycle.
- Timeout:
  - Counter increments every cycle, saturating.
  - On reaching TIMEOUT_CYCLES: value_valid = 0; minutes/seconds hold their last value; match count = 0.
- Sticky errors: clear only on clear_err or reset. A new error in the same cycle as clear_err leaves the flag set (error wins).
- Reset mid-frame: partial captures are lost. After reset release, decoding restarts from an empty mask.

Test Plan:
(SETTLE_CYCLES=4, STABLE_FRAMES=2, TIMEOUT_CYCLES=64; each digit held 10 cycles)
1. Scan 12:34 twice -> first frame: frame_strobe, value_valid=0. Second frame: frame_strobe, minutes=12, seconds=34, value_valid=1, no errors.
2. Scan 12:34 then 12:35, 12:35 -> outputs stay 12:34 after the first 12:35 frame, then update to 12:35 on the second.
3. Sec-tens cathode=1111111 in one frame -> err_pattern=1, no frame_strobe for that frame, outputs unchanged. clear_err -> err_pattern=0.
4. Valid frames of 07:61 -> err_range=1, no strobe. Anode=0011 held for 10 cycles -> err_anode=1, no capture.
5. After 12:34 is valid, hold anode=1111 for 70 cycles -> value_valid=0 at cycle 64, minutes=12 and seconds=34 held, no error.
6. Digit glitch shorter than 4 samples -> ignored. Assert reset mid-frame -> all outputs 0 immediately; next two full 59:59 frames -> minutes=59, seconds=59, value_valid=1.
